fc_layer_link: RTL and testbench



---
 rtl/fc_layer_link.sv | 129 ++++++++++++
 tb/tb_fc_layer_link.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_link.sv
// Inter-layer link: buffers layer N activations in a FIFO, writes them into layer N+1's input
// buffer while it is idle, then pulses start. Define FC_LINK_RELU_EN to clamp negative values to zero.
module fc_layer_link #(
    parameter int datatype_size = 8,
    parameter int vector_size   = 500,
    parameter int fifo_depth    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_valid,
    input  logic [datatype_size-1:0]       i_data,
    output logic                           o_ready,
    input  logic                           i_next_busy,
    output logic                           o_ibuf_we,
    output logic [datatype_size-1:0]       o_ibuf_wr_data,
    output logic [$clog2(vector_size)-1:0] o_ibuf_addr,
    output logic                           o_start,
    output logic                           o_busy
);

    localparam int addr_w = $clog2(vector_size);
    localparam int ptr_w  = $clog2(fifo_depth);
    localparam int cnt_w  = $clog2(fifo_depth + 1);
    localparam logic [addr_w-1:0] last_addr = addr_w'(vector_size - 1);
    localparam logic [cnt_w-1:0]  full_cnt  = cnt_w'(fifo_depth);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [datatype_size-1:0] mem [fifo_depth];
    logic [ptr_w-1:0]         wr_ptr;
    logic [ptr_w-1:0]         rd_ptr;
    logic [cnt_w-1:0]         count;
    logic [addr_w-1:0]        wr_cnt;
    logic                     push;
    logic                     pop;
    logic                     start_next;
    logic [datatype_size-1:0] rd_data;
    logic [datatype_size-1:0] wr_value;

    // Readiness comes from the registered count, so a pop never frees a slot in the same cycle.
    assign o_ready = (count != full_cnt);
    assign push    = i_valid && o_ready;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array is not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (pop && (wr_cnt == last_addr)) state_next = START;
            START:   state_next = ACK;
            ACK:     if (i_next_busy) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        pop        = (state == FILL) && (count != '0) && !i_next_busy;
        start_next = (state == START);
    end

`ifdef FC_LINK_RELU_EN
    assign wr_value = rd_data[datatype_size-1] ? '0 : rd_data;
`else
    assign wr_value = rd_data;
`endif

    // Write port and start pulse are registered; wr_cnt returns to 0 on the last pop of a vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_ibuf_we      <= 1'b0;
            o_ibuf_wr_data <= '0;
            o_ibuf_addr    <= '0;
            o_start        <= 1'b0;
            wr_cnt         <= '0;
        end else begin
            o_ibuf_we <= pop;
            o_start   <= start_next;
            if (pop) begin
                o_ibuf_wr_data <= wr_value;
                o_ibuf_addr    <= wr_cnt;
                wr_cnt         <= (wr_cnt == last_addr) ? '0 : wr_cnt + 1'b1;
            end
        end
    end

    assign o_busy = (count != '0) || (wr_cnt != '0) || (state != FILL) || o_ibuf_we;

endmodule

// File: tb/tb_fc_layer_link.sv
// Self-checking bench for fc_layer_link: a queue-based reference model predicts write order,
// addresses and start pulses; FC_LINK_RELU_EN selects the expected data transform.
module tb_fc_layer_link;

    localparam int dw = 8;
    localparam int vs = 4;
    localparam int fd = 4;
    localparam int aw = $clog2(vs);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic [dw-1:0] i_data = '0;
    logic          i_next_busy = 1'b0;
    logic          o_ready;
    logic          o_ibuf_we;
    logic [dw-1:0] o_ibuf_wr_data;
    logic [aw-1:0] o_ibuf_addr;
    logic          o_start;
    logic          o_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Observed write/start log, appended only by the monitor.
    logic [aw-1:0] wa_q[$];
    logic [dw-1:0] wd_q[$];
    int            wc_q[$];
    int            sc_q[$];
    int            viol = 0;
    logic          prev_busy = 1'b0;

    fc_layer_link #(
        .datatype_size(dw),
        .vector_size  (vs),
        .fifo_depth   (fd)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_ready       (o_ready),
        .i_next_busy   (i_next_busy),
        .o_ibuf_we     (o_ibuf_we),
        .o_ibuf_wr_data(o_ibuf_wr_data),
        .o_ibuf_addr   (o_ibuf_addr),
        .o_start       (o_start),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_ibuf_we) begin
            wa_q.push_back(o_ibuf_addr);
            wd_q.push_back(o_ibuf_wr_data);
            wc_q.push_back(cyc);
            if (prev_busy) viol++;
        end
        if (o_start) sc_q.push_back(cyc);
        prev_busy = i_next_busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    // Expected value written to the input buffer for a pushed element.
    function automatic logic [dw-1:0] model_wr(input logic [dw-1:0] d);
`ifdef FC_LINK_RELU_EN
        return ($signed(d) < 0) ? '0 : d;
`else
        return d;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_valid = 1'b0;
        i_next_busy = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [dw-1:0] d);
        bit done;
        done = 1'b0;
        i_valid = 1'b1;
        i_data = d;
        for (int k = 0; k < 200 && !done; k++) begin
            if (o_ready) done = 1'b1;
            step();
        end
        i_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL push_timeout: o_ready stayed 0, required 1 within 200 cycles");
        end
    endtask

    // Waits for a start pulse, then holds downstream busy for three cycles.
    task automatic ack_once(output int fall);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (o_start) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_wait: o_start never seen, required 1 within 200 cycles");
            fall = cyc;
        end else begin
            step();
            i_next_busy = 1'b1;
            step();
            step();
            step();
            i_next_busy = 1'b0;
            fall = cyc;
        end
    endtask

    task automatic check_writes(input string name, input int base, input logic [dw-1:0] exp[$]);
        checks++;
        if (wd_q.size() !== base + exp.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d writes, required %0d", name, wd_q.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < wd_q.size()) begin
                checks++;
                if (wd_q[base+i] !== model_wr(exp[i]) || wa_q[base+i] !== aw'(i % vs)) begin
                    errors++;
                    $display("FAIL %s_write%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                             name, i, wa_q[base+i], wd_q[base+i], i % vs, model_wr(exp[i]));
                end
            end
        end
    endtask

    task automatic test_reset();
        int b;
        b = wd_q.size();
        rst = 1'b1;
        i_valid = 1'b1;
        i_data = dw'($urandom);
        i_next_busy = 1'b0;
        step();
        step();
        checks++;
        if (o_ready !== 1'b1 || o_ibuf_we !== 1'b0 || o_start !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b we=%b start=%b busy=%b, required 1 0 0 0",
                     o_ready, o_ibuf_we, o_start, o_busy);
        end
        checks++;
        if (o_ibuf_wr_data !== '0 || o_ibuf_addr !== '0) begin
            errors++;
            $display("FAIL reset_data: got data=%h addr=%0d, required 0 0", o_ibuf_wr_data, o_ibuf_addr);
        end
        rst = 1'b0;
        i_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (wd_q.size() !== b) begin
            errors++;
            $display("FAIL reset_flush: got %0d writes, required 0", wd_q.size() - b);
        end
    endtask

    task automatic test_single_vector();
        int c0, b, sb;
        logic [dw-1:0] exp[$];
        do_reset();
        c0 = cyc;
        b = wd_q.size();
        sb = sc_q.size();
        for (int i = 0; i < vs; i++) begin
            exp.push_back(dw'(i + 1));
            push(dw'(i + 1));
        end
        repeat (3) step();
        check_writes("single", b, exp);
        for (int i = 0; i < vs; i++) begin
            if (b + i < wc_q.size()) begin
                checks++;
                if (wc_q[b+i] !== c0 + 2 + i) begin
                    errors++;
                    $display("FAIL single_cycle%0d: got cycle %0d, required %0d", i, wc_q[b+i] - c0, 2 + i);
                end
            end
        end
        checks++;
        if (sc_q.size() !== sb + 1) begin
            errors++;
            $display("FAIL single_start_count: got %0d, required 1", sc_q.size() - sb);
        end else begin
            checks++;
            if (sc_q[sb] !== c0 + 6) begin
                errors++;
                $display("FAIL single_start_cycle: got %0d, required 6", sc_q[sb] - c0);
            end
        end
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_ack: got %b, required 1", o_busy);
        end
        i_next_busy = 1'b1;
        step();
        i_next_busy = 1'b0;
        step();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_idle: got %b, required 0", o_busy);
        end
    endtask

    task automatic test_backpressure();
        int b, sb, v0, model_cnt;
        logic [dw-1:0] exp[$];
        do_reset();
        b = wd_q.size();
        sb = sc_q.size();
        v0 = viol;
        model_cnt = 0;
        i_next_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_valid = 1'b1;
            i_data = dw'($urandom);
            checks++;
            if (o_ready !== (model_cnt < fd)) begin
                errors++;
                $display("FAIL bp_ready%0d: got %b, required %b", i, o_ready, model_cnt < fd);
            end
            if (model_cnt < fd) begin
                exp.push_back(i_data);
                model_cnt++;
            end
            step();
        end
        i_valid = 1'b0;
        checks++;
        if (o_ready !== 1'b0 || wd_q.size() !== b) begin
            errors++;
            $display("FAIL bp_hold: got ready=%b writes=%0d, required ready=0 writes=0", o_ready, wd_q.size() - b);
        end
        i_next_busy = 1'b0;
        repeat (7) step();
        check_writes("bp", b, exp);
        checks++;
        if (o_ready !== 1'b1 || sc_q.size() !== sb + 1 || viol !== v0) begin
            errors++;
            $display("FAIL bp_release: got ready=%b starts=%0d busy_writes=%0d, required 1 1 0",
                     o_ready, sc_q.size() - sb, viol - v0);
        end
        i_next_busy = 1'b1;
        step();
        i_next_busy = 1'b0;
        step();
    endtask

    task automatic test_vector_boundary();
        int b, sb, v0, f1, f2;
        logic [dw-1:0] exp[$];
        do_reset();
        b = wd_q.size();
        sb = sc_q.size();
        v0 = viol;
        for (int i = 0; i < 2 * vs; i++) exp.push_back(dw'($urandom));
        fork
            begin
                for (int i = 0; i < 2 * vs; i++) push(exp[i]);
            end
            begin
                ack_once(f1);
                ack_once(f2);
            end
        join
        repeat (2) step();
        check_writes("vb", b, exp);
        if (wc_q.size() >= b + 2 * vs) begin
            checks++;
            if (wc_q[b+vs] < f1 + 1) begin
                errors++;
                $display("FAIL vb_second_early: got write cycle %0d, required >= %0d", wc_q[b+vs], f1 + 1);
            end
        end
        checks++;
        if (sc_q.size() !== sb + 2 || viol !== v0) begin
            errors++;
            $display("FAIL vb_starts: got starts=%0d busy_writes=%0d, required 2 0", sc_q.size() - sb, viol - v0);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL vb_idle: got busy=%b, required 0", o_busy);
        end
    endtask

    task automatic test_wrap();
        int b, f1, f2;
        logic [dw-1:0] exp[$];
        do_reset();
        b = wd_q.size();
        for (int i = 0; i < 10; i++) exp.push_back(dw'($urandom));
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    push(exp[i]);
                end
            end
            begin
                ack_once(f1);
                ack_once(f2);
            end
        join
        repeat (8) step();
        check_writes("wrap", b, exp);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL wrap_partial_busy: got %b, required 1", o_busy);
        end
    endtask

    task automatic test_mid_reset();
        int b, sb;
        logic [dw-1:0] exp[$];
        do_reset();
        b = wd_q.size();
        sb = sc_q.size();
        push(dw'($urandom));
        push(dw'($urandom));
        repeat (3) step();
        checks++;
        if (wd_q.size() !== b + 2) begin
            errors++;
            $display("FAIL mr_partial: got %0d writes, required 2", wd_q.size() - b);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL mr_after: got busy=%b ready=%b, required 0 1", o_busy, o_ready);
        end
        b = wd_q.size();
        for (int i = 0; i < vs; i++) begin
            exp.push_back(dw'($urandom));
            push(exp[i]);
        end
        repeat (5) step();
        check_writes("mr", b, exp);
        checks++;
        if (sc_q.size() !== sb + 1) begin
            errors++;
            $display("FAIL mr_starts: got %0d, required 1", sc_q.size() - sb);
        end
        i_next_busy = 1'b1;
        step();
        i_next_busy = 1'b0;
        step();
    endtask

    task automatic test_relu();
        int b;
        logic [dw-1:0] exp[$];
        do_reset();
        b = wd_q.size();
        exp.push_back(8'hF0);
        exp.push_back(8'h05);
        push(8'hF0);
        push(8'h05);
        repeat (4) step();
        check_writes("relu", b, exp);
    endtask

    initial begin
        test_reset();
        test_single_vector();
        test_backpressure();
        test_vector_boundary();
        test_wrap();
        test_mid_reset();
        test_relu();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
